// File: rtl/keypad_cursor_ctrl.sv
// Cursor navigation, auto-repeat and key hand-off for the 6x4 on-screen keypad.
// Also produces the registered per-pixel cursor highlight for the VGA mixer.
//
// state  | meaning
// S_IDLE | waiting for a direction button rising edge
// S_HOLD | button held, counting down the initial repeat delay
// S_RPT  | button still held, counting down between auto-repeats
module keypad_cursor_ctrl #(
   parameter int COLS         = 6,
   parameter int ROWS         = 4,
   parameter int X_STEP       = 100,
   parameter int Y_STEP       = 100,
   parameter int X_OFFSET     = 10,
   parameter int Y_OFFSET     = 10,
   parameter int CURSOR_W     = 80,
   parameter int CURSOR_H     = 80,
   parameter int REPEAT_DELAY = 54_000_000,
   parameter int REPEAT_RATE  = 16_200_000
) (
   input  logic        clk_vga,
   input  logic        rst,
   input  logic        btn_up,
   input  logic        btn_down,
   input  logic        btn_left,
   input  logic        btn_right,
   input  logic        btn_enter,
   input  logic [10:0] hc_visible,
   input  logic [10:0] vc_visible,
   input  logic        key_ready,
   output logic [2:0]  cursor_col,
   output logic [1:0]  cursor_row,
   output logic [4:0]  key_index,
   output logic [7:0]  key_code,
   output logic        key_valid,
   output logic        in_cursor
);

   localparam int CNT_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
   localparam int CW      = $clog2(CNT_MAX + 1);
   localparam logic [CW-1:0] LOAD_DELAY = CW'(REPEAT_DELAY - 1);
   localparam logic [CW-1:0] LOAD_RATE  = CW'(REPEAT_RATE - 1);
   localparam logic [2:0]    COL_LAST   = 3'(COLS - 1);
   localparam logic [1:0]    ROW_LAST   = 2'(ROWS - 1);
   localparam logic [0:23][7:0] KEY_MAP = "0123+-4567*|89AB&?CDEF>!";

   typedef enum logic [1:0] {S_IDLE, S_HOLD, S_RPT} state_t;

   state_t          r_state, w_state_nxt;
   logic [CW-1:0]   r_cnt, w_cnt_nxt;
   logic [1:0]      r_dir, w_dir_nxt, w_sel, w_move_dir;
   logic            w_move;
   logic [2:0]      r_col, w_col_nxt;
   logic [1:0]      r_row, w_row_nxt;
   logic [4:0]      r_btn_low;
   logic [3:0]      w_dir_lvl;
   logic [4:0]      w_rise;
   logic [4:0]      w_key_idx;
   logic            r_key_valid;
   logic [4:0]      r_key_index;
   logic [7:0]      r_key_code;
   logic            r_in_cursor;
   logic [11:0]     w_x0, w_y0, w_hc, w_vc;
   logic            w_in_cursor;

   // A level counts as an edge only once it has been seen low; reset clears
   // the seen-low flags so buttons held through reset stay inert.
   assign w_dir_lvl = {btn_right, btn_left, btn_down, btn_up};
   assign w_rise    = {btn_enter, w_dir_lvl} & r_btn_low;

   always_comb begin
      w_sel = 2'd3;
      if (w_rise[0])      w_sel = 2'd0;
      else if (w_rise[1]) w_sel = 2'd1;
      else if (w_rise[2]) w_sel = 2'd2;
   end

   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_dir_nxt   = r_dir;
      w_move      = 1'b0;
      w_move_dir  = r_dir;
      case (r_state)
         S_IDLE: begin
            if (|w_rise[3:0]) begin
               w_move      = 1'b1;
               w_move_dir  = w_sel;
               w_dir_nxt   = w_sel;
               w_cnt_nxt   = LOAD_DELAY;
               w_state_nxt = S_HOLD;
            end
         end
         S_HOLD, S_RPT: begin
            if (!w_dir_lvl[r_dir]) begin
               w_state_nxt = S_IDLE;
            end else if (r_cnt == '0) begin
               w_move      = 1'b1;
               w_cnt_nxt   = LOAD_RATE;
               w_state_nxt = S_RPT;
            end else begin
               w_cnt_nxt = r_cnt - 1'b1;
            end
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_comb begin
      w_col_nxt = r_col;
      w_row_nxt = r_row;
      if (w_move) begin
         case (w_move_dir)
            2'd0:    w_row_nxt = (r_row == 2'd0)     ? ROW_LAST : r_row - 2'd1;
            2'd1:    w_row_nxt = (r_row == ROW_LAST) ? 2'd0     : r_row + 2'd1;
            2'd2:    w_col_nxt = (r_col == 3'd0)     ? COL_LAST : r_col - 3'd1;
            default: w_col_nxt = (r_col == COL_LAST) ? 3'd0     : r_col + 3'd1;
         endcase
      end
   end

   always_ff @(posedge clk_vga or negedge rst) begin
      if (!rst) begin
         r_state   <= S_IDLE;
         r_cnt     <= '0;
         r_dir     <= '0;
         r_col     <= '0;
         r_row     <= '0;
         r_btn_low <= '0;
      end else begin
         r_state   <= w_state_nxt;
         r_cnt     <= w_cnt_nxt;
         r_dir     <= w_dir_nxt;
         r_col     <= w_col_nxt;
         r_row     <= w_row_nxt;
         r_btn_low <= ~{btn_enter, w_dir_lvl};
      end
   end

   assign w_key_idx = 5'(r_row) * 5'(COLS) + 5'(r_col);

   assign w_hc = {1'b0, hc_visible};
   assign w_vc = {1'b0, vc_visible};
   assign w_x0 = 12'(r_col) * 12'(X_STEP) + 12'(X_OFFSET);
   assign w_y0 = 12'(r_row) * 12'(Y_STEP) + 12'(Y_OFFSET);
   assign w_in_cursor = (w_hc >= w_x0) && (w_hc < w_x0 + 12'(CURSOR_W)) &&
                        (w_vc >= w_y0) && (w_vc < w_y0 + 12'(CURSOR_H));

   // Enter latches the pre-move cursor; further enters are dropped until the core accepts.
   always_ff @(posedge clk_vga or negedge rst) begin
      if (!rst) begin
         r_key_valid <= 1'b0;
         r_key_index <= '0;
         r_key_code  <= 8'h30;
         r_in_cursor <= 1'b0;
      end else begin
         r_in_cursor <= w_in_cursor;
         if (w_rise[4] && !r_key_valid) begin
            r_key_valid <= 1'b1;
            r_key_index <= w_key_idx;
            r_key_code  <= KEY_MAP[w_key_idx];
         end else if (r_key_valid && key_ready) begin
            r_key_valid <= 1'b0;
         end
      end
   end

   assign cursor_col = r_col;
   assign cursor_row = r_row;
   assign key_index  = r_key_index;
   assign key_code   = r_key_code;
   assign key_valid  = r_key_valid;
   assign in_cursor  = r_in_cursor;

endmodule

// File: tb/tb_keypad_cursor_ctrl.sv
// Self-checking bench for keypad_cursor_ctrl against a cycle-level behavioural model
// that tracks cursor position with modular arithmetic and hold time as elapsed cycles.
module tb_keypad_cursor_ctrl;

   localparam int DLY  = 10;
   localparam int RATE = 4;

   logic        clk_vga = 1'b0;
   logic        rst = 1'b0;
   logic        b_up = 1'b0, b_down = 1'b0, b_left = 1'b0, b_right = 1'b0, b_enter = 1'b0;
   logic [10:0] hc = '0, vc = '0;
   logic        key_ready = 1'b0;
   logic [2:0]  cursor_col;
   logic [1:0]  cursor_row;
   logic [4:0]  key_index;
   logic [7:0]  key_code;
   logic        key_valid;
   logic        in_cursor;

   keypad_cursor_ctrl #(.REPEAT_DELAY(DLY), .REPEAT_RATE(RATE)) dut (
      .clk_vga(clk_vga), .rst(rst),
      .btn_up(b_up), .btn_down(b_down), .btn_left(b_left), .btn_right(b_right),
      .btn_enter(b_enter), .hc_visible(hc), .vc_visible(vc), .key_ready(key_ready),
      .cursor_col(cursor_col), .cursor_row(cursor_row), .key_index(key_index),
      .key_code(key_code), .key_valid(key_valid), .in_cursor(in_cursor)
   );

   always #5 clk_vga = ~clk_vga;

   int checks = 0;
   int errors = 0;

   string      KM = "0123+-4567*|89AB&?CDEF>!";
   int         m_col, m_row, m_idx, m_hold, m_t;
   logic [7:0] m_code;
   logic       m_valid, m_inc;
   logic [4:0] m_armed;

   function automatic logic inside_sq(int c, int r, int x, int y);
      return (x >= c*100+10) && (x < c*100+90) && (y >= r*100+10) && (y < r*100+90);
   endfunction

   task automatic model_reset();
      m_col = 0; m_row = 0; m_idx = 0; m_code = 8'h30; m_valid = 1'b0; m_inc = 1'b0;
      m_hold = -1; m_t = 0; m_armed = '0;
   endtask

   // Advances the model across one rising clock edge using the inputs currently applied.
   task automatic model_step();
      logic [3:0] d;
      int dir;
      if (!rst) begin
         model_reset();
         return;
      end
      d = {b_right, b_left, b_down, b_up};
      m_inc = inside_sq(m_col, m_row, int'(hc), int'(vc));
      if (b_enter && m_armed[4] && !m_valid) begin
         m_idx = m_row*6 + m_col;
         m_code = KM.getc(m_idx);
         m_valid = 1'b1;
      end else if (m_valid && key_ready) begin
         m_valid = 1'b0;
      end
      dir = -1;
      if (m_hold >= 0) begin
         if (d[m_hold]) begin
            m_t++;
            if (m_t == DLY || (m_t > DLY && (m_t - DLY) % RATE == 0)) dir = m_hold;
         end else begin
            m_hold = -1;
         end
      end else begin
         for (int i = 3; i >= 0; i--) if (d[i] && m_armed[i]) dir = i;
         if (dir >= 0) begin
            m_hold = dir;
            m_t = 0;
         end
      end
      case (dir)
         0: m_row = (m_row + 3) % 4;
         1: m_row = (m_row + 1) % 4;
         2: m_col = (m_col + 5) % 6;
         3: m_col = (m_col + 1) % 6;
         default: ;
      endcase
      m_armed = ~{b_enter, d};
   endtask

   task automatic cyc();
      model_step();
      @(posedge clk_vga);
      #1;
   endtask

   task automatic goto(int c, int r);
      for (int i = 0; i < 6 && m_col != c; i++) begin
         b_right = 1'b1; cyc(); b_right = 1'b0; cyc();
      end
      for (int i = 0; i < 4 && m_row != r; i++) begin
         b_down = 1'b1; cyc(); b_down = 1'b0; cyc();
      end
   endtask

   task automatic test_reset();
      rst = 1'b0;
      cyc(); cyc();
      checks++; if (cursor_col !== 3'd0) begin errors++; $display("FAIL reset_col got %0d want 0", cursor_col); end
      checks++; if (cursor_row !== 2'd0) begin errors++; $display("FAIL reset_row got %0d want 0", cursor_row); end
      checks++; if (key_index !== 5'd0) begin errors++; $display("FAIL reset_idx got %0d want 0", key_index); end
      checks++; if (key_code !== 8'h30) begin errors++; $display("FAIL reset_code got %h want 30", key_code); end
      checks++; if (key_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", key_valid); end
      checks++; if (in_cursor !== 1'b0) begin errors++; $display("FAIL reset_incur got %b want 0", in_cursor); end
      rst = 1'b1;
      cyc(); cyc();
   endtask

   task automatic test_right_pulses();
      int seq [7] = '{1, 2, 3, 4, 5, 0, 1};
      for (int i = 0; i < 7; i++) begin
         b_right = 1'b1; cyc(); b_right = 1'b0;
         checks++; if (cursor_col !== 3'(seq[i])) begin errors++; $display("FAIL right_pulse%0d col got %0d want %0d", i, cursor_col, seq[i]); end
         checks++; if (cursor_col !== 3'(m_col) || cursor_row !== 2'(m_row)) begin errors++; $display("FAIL right_pulse%0d model got %0d,%0d want %0d,%0d", i, cursor_col, cursor_row, m_col, m_row); end
         cyc(); cyc();
      end
   endtask

   task automatic test_hold_repeat();
      int moves = 0;
      logic [1:0] prev;
      prev = cursor_row;
      b_down = 1'b1;
      for (int i = 0; i < 30; i++) begin
         cyc();
         if (cursor_row !== prev) moves++;
         prev = cursor_row;
         checks++; if (cursor_row !== 2'(m_row)) begin errors++; $display("FAIL hold_row cyc%0d got %0d want %0d", i, cursor_row, m_row); end
      end
      b_down = 1'b0;
      checks++; if (moves != 6) begin errors++; $display("FAIL hold_moves got %0d want 6", moves); end
      checks++; if (cursor_row !== 2'd2) begin errors++; $display("FAIL hold_final_row got %0d want 2", cursor_row); end
      for (int i = 0; i < 8; i++) cyc();
      checks++; if (cursor_row !== 2'd2) begin errors++; $display("FAIL hold_after_release got %0d want 2", cursor_row); end
   endtask

   task automatic test_enter_handshake();
      goto(3, 2);
      b_enter = 1'b1; cyc(); b_enter = 1'b0;
      for (int i = 0; i < 20; i++) begin
         if (i == 5) b_right = 1'b1;
         if (i == 6) b_right = 1'b0;
         if (i == 10) b_enter = 1'b1;
         if (i == 11) b_enter = 1'b0;
         cyc();
         checks++; if (key_valid !== 1'b1 || key_index !== 5'd15 || key_code !== 8'h42) begin errors++; $display("FAIL enter_hold cyc%0d got v%b i%0d c%h want v1 i15 c42", i, key_valid, key_index, key_code); end
         checks++; if (key_valid !== m_valid || key_code !== m_code) begin errors++; $display("FAIL enter_model cyc%0d got v%b c%h want v%b c%h", i, key_valid, key_code, m_valid, m_code); end
      end
      checks++; if (cursor_col !== 3'd4) begin errors++; $display("FAIL enter_move col got %0d want 4", cursor_col); end
      key_ready = 1'b1; cyc(); key_ready = 1'b0;
      checks++; if (key_valid !== 1'b0) begin errors++; $display("FAIL enter_accept valid got %b want 0", key_valid); end
      cyc();
   endtask

   task automatic test_simultaneous();
      goto(0, 0);
      b_up = 1'b1; b_left = 1'b1; cyc(); b_up = 1'b0; b_left = 1'b0; cyc();
      checks++; if (cursor_col !== 3'd0 || cursor_row !== 2'd3) begin errors++; $display("FAIL simul_prio got %0d,%0d want 0,3", cursor_col, cursor_row); end
      goto(0, 0);
      b_up = 1'b1; b_left = 1'b1; b_enter = 1'b1; cyc();
      b_up = 1'b0; b_left = 1'b0; b_enter = 1'b0; cyc();
      checks++; if (cursor_col !== 3'd0 || cursor_row !== 2'd3) begin errors++; $display("FAIL simul_enter_pos got %0d,%0d want 0,3", cursor_col, cursor_row); end
      checks++; if (key_valid !== 1'b1 || key_code !== 8'h30 || key_index !== 5'd0) begin errors++; $display("FAIL simul_enter_code got v%b c%h i%0d want v1 c30 i0", key_valid, key_code, key_index); end
      key_ready = 1'b1; cyc(); key_ready = 1'b0;
      checks++; if (key_valid !== 1'b0) begin errors++; $display("FAIL simul_accept valid got %b want 0", key_valid); end
   endtask

   task automatic test_highlight();
      logic want;
      goto(1, 2);
      vc = 11'd250;
      for (int x = 100; x <= 200; x++) begin
         hc = 11'(x);
         cyc();
         want = (x >= 110 && x <= 189);
         checks++; if (in_cursor !== want || in_cursor !== m_inc) begin errors++; $display("FAIL highlight hc%0d got %b want %b", x, in_cursor, want); end
      end
      vc = 11'd290; hc = 11'd150; cyc();
      checks++; if (in_cursor !== 1'b0) begin errors++; $display("FAIL highlight_vc290 got %b want 0", in_cursor); end
      hc = '0; vc = '0; cyc();
   endtask

   task automatic test_random();
      int rem = 0;
      logic [3:0] dirs = '0;
      for (int i = 0; i < 1500; i++) begin
         if (rem == 0) begin
            dirs = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'(1 << $urandom_range(0, 3));
            if ($urandom_range(0, 2) == 0) dirs = '0;
            rem = $urandom_range(1, 25);
         end
         rem--;
         {b_right, b_left, b_down, b_up} = dirs;
         b_enter   = ($urandom_range(0, 5) == 0);
         key_ready = ($urandom_range(0, 3) == 0);
         hc = 11'($urandom_range(0, 650));
         vc = 11'($urandom_range(0, 450));
         cyc();
         checks++; if (cursor_col !== 3'(m_col) || cursor_row !== 2'(m_row)) begin errors++; $display("FAIL rand_cursor cyc%0d got %0d,%0d want %0d,%0d", i, cursor_col, cursor_row, m_col, m_row); end
         checks++; if (key_valid !== m_valid) begin errors++; $display("FAIL rand_valid cyc%0d got %b want %b", i, key_valid, m_valid); end
         checks++; if (key_index !== 5'(m_idx) || key_code !== m_code) begin errors++; $display("FAIL rand_key cyc%0d got i%0d c%h want i%0d c%h", i, key_index, key_code, m_idx, m_code); end
         checks++; if (in_cursor !== m_inc) begin errors++; $display("FAIL rand_incur cyc%0d got %b want %b", i, in_cursor, m_inc); end
      end
      {b_right, b_left, b_down, b_up} = '0;
      b_enter = 1'b0; key_ready = 1'b0; hc = '0; vc = '0;
      for (int i = 0; i < 3; i++) cyc();
   endtask

   task automatic test_reset_mid();
      goto(2, 1);
      hc = 11'd250; vc = 11'd150;
      b_enter = 1'b1; cyc(); b_enter = 1'b0;
      b_right = 1'b1;
      for (int i = 0; i < 16; i++) cyc();
      checks++; if (key_valid !== 1'b1 || in_cursor !== m_inc) begin errors++; $display("FAIL rstmid_pre got v%b ic%b want v1 ic%b", key_valid, in_cursor, m_inc); end
      #2 rst = 1'b0;
      #1;
      model_reset();
      checks++; if (cursor_col !== 3'd0 || cursor_row !== 2'd0) begin errors++; $display("FAIL rstmid_cursor got %0d,%0d want 0,0", cursor_col, cursor_row); end
      checks++; if (key_valid !== 1'b0 || key_index !== 5'd0 || key_code !== 8'h30) begin errors++; $display("FAIL rstmid_key got v%b i%0d c%h want v0 i0 c30", key_valid, key_index, key_code); end
      checks++; if (in_cursor !== 1'b0) begin errors++; $display("FAIL rstmid_incur got %b want 0", in_cursor); end
      cyc(); cyc();
      rst = 1'b1;
      hc = '0; vc = '0;
      for (int i = 0; i < 6; i++) begin
         cyc();
         checks++; if (cursor_col !== 3'd0 || cursor_col !== 3'(m_col)) begin errors++; $display("FAIL rstmid_held cyc%0d col got %0d want 0", i, cursor_col); end
      end
      b_right = 1'b0; cyc();
      b_right = 1'b1; cyc(); b_right = 1'b0;
      checks++; if (cursor_col !== 3'd1 || cursor_col !== 3'(m_col)) begin errors++; $display("FAIL rstmid_repress col got %0d want 1", cursor_col); end
      cyc();
   endtask

   initial begin
      model_reset();
      test_reset();
      test_right_pulses();
      test_hold_repeat();
      test_enter_handshake();
      test_simultaneous();
      test_highlight();
      test_random();
      test_reset_mid();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
